linked_timer_fsm: RTL and testbench



---
 rtl/linked_timer_fsm.sv | 91 +++++++++
 tb/tb_linked_timer_fsm.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/linked_timer_fsm.sv
// Worker timer for the linked controller: a START accepted from IDLE arms a down-counter;
// READY is raised in DONE once HOLD_CYCLES edges have elapsed and is held until RESET.
module linked_timer_fsm #(
   parameter int WIDTH     = 8,
   parameter int RETRIGGER = 0
) (
   input  logic             CLK,
   input  logic             N_RESET,
   input  logic             RESET,
   input  logic             START,
   input  logic [WIDTH-1:0] HOLD_CYCLES,
   output logic             READY,
   output logic             BUSY,
   output logic [WIDTH-1:0] COUNT
);

   // Handshake: START is accepted on any rising edge that finds the machine in IDLE
   // with RESET low; READY then stays high (one-way) until the controller clears with RESET.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CNT   = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] cnt, cnt_nx;
   logic             hold_zero;

   assign hold_zero = (HOLD_CYCLES == '0);

   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (RESET) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  if (hold_zero) begin
                     state_nx = DONE;
                     cnt_nx   = '0;
                  end else begin
                     state_nx = CNT;
                     cnt_nx   = HOLD_CYCLES;
                  end
               end
            end
            CNT: begin
               if ((RETRIGGER != 0) && START) begin
                  if (hold_zero) begin
                     state_nx = DONE;
                     cnt_nx   = '0;
                  end else begin
                     cnt_nx   = HOLD_CYCLES;
                  end
               end else if (cnt <= WIDTH'(1)) begin
                  // <= rather than == so a corrupted zero count cannot wrap
                  state_nx = DONE;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx   = cnt - WIDTH'(1);
               end
            end
            DONE: begin
               state_nx = DONE;
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   assign READY = (state == DONE);
   assign BUSY  = (state == CNT);
   assign COUNT = cnt;

endmodule

// File: tb/tb_linked_timer_fsm.sv
// Directed bench for linked_timer_fsm: one instance without and one with retrigger,
// driven from shared inputs and checked against hand-computed READY/BUSY/COUNT values.
module tb_linked_timer_fsm;

   localparam int W = 8;

   logic         CLK;
   logic         N_RESET;
   logic         RESET;
   logic         START;
   logic [W-1:0] HOLD_CYCLES;
   logic         ready0, busy0, ready1, busy1;
   logic [W-1:0] count0, count1;

   int n_cmp = 0;
   int n_err = 0;
   logic [W+1:0] exp_q[$];

   linked_timer_fsm #(.WIDTH(W), .RETRIGGER(0)) dut0 (
      .CLK(CLK), .N_RESET(N_RESET), .RESET(RESET), .START(START),
      .HOLD_CYCLES(HOLD_CYCLES), .READY(ready0), .BUSY(busy0), .COUNT(count0)
   );

   linked_timer_fsm #(.WIDTH(W), .RETRIGGER(1)) dut1 (
      .CLK(CLK), .N_RESET(N_RESET), .RESET(RESET), .START(START),
      .HOLD_CYCLES(HOLD_CYCLES), .READY(ready1), .BUSY(busy1), .COUNT(count1)
   );

   // clock
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // advance one rising edge and settle away from it
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // scoreboard: expected {READY,BUSY,COUNT} is queued then compared to instance 'inst'
   task automatic chk(input int inst, input string tag, input logic r, input logic b,
                      input logic [W-1:0] c);
      logic [W+1:0] exp_v;
      logic [W+1:0] obs_v;
      exp_q.push_back({r, b, c});
      exp_v = exp_q.pop_front();
      obs_v = (inst == 0) ? {ready0, busy0, count0} : {ready1, busy1, count1};
      n_cmp++;
      assert (obs_v === exp_v) else begin
         n_err++;
         $error("FAIL %s inst%0d: observed ready=%0b busy=%0b count=%0d expected ready=%0b busy=%0b count=%0d",
                tag, inst, obs_v[W+1], obs_v[W], obs_v[W-1:0], exp_v[W+1], exp_v[W], exp_v[W-1:0]);
      end
   endtask

   task automatic chk_both(input string tag, input logic r, input logic b, input logic [W-1:0] c);
      chk(0, tag, r, b, c);
      chk(1, tag, r, b, c);
   endtask

   task automatic clear();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
   endtask

   task automatic fire(input logic [W-1:0] hold);
      HOLD_CYCLES = hold;
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   initial begin
      N_RESET = 1'b1;
      RESET = 1'b1;
      START = 1'b0;
      HOLD_CYCLES = '0;
      tick();
      tick();
      chk_both("clr_init", 1'b0, 1'b0, 8'd0);

      // 1: async reset mid-count, then synchronous clear for 3 cycles
      RESET = 1'b0;
      fire(8'd5);
      chk_both("pre_arst", 1'b0, 1'b1, 8'd5);
      #3 N_RESET = 1'b0;
      #1 chk_both("arst_immediate", 1'b0, 1'b0, 8'd0);
      #2 N_RESET = 1'b1;
      RESET = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_both("sync_clear", 1'b0, 1'b0, 8'd0);
      end
      RESET = 1'b0;

      // 2: normal hold of 3
      fire(8'd3);
      chk_both("hold3_c3", 1'b0, 1'b1, 8'd3);
      tick();
      chk_both("hold3_c2", 1'b0, 1'b1, 8'd2);
      tick();
      chk_both("hold3_c1", 1'b0, 1'b1, 8'd1);
      tick();
      chk_both("hold3_done", 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_both("hold3_held", 1'b1, 1'b0, 8'd0);
      end
      clear();
      chk_both("hold3_clear", 1'b0, 1'b0, 8'd0);

      // 3: zero hold goes straight to DONE
      fire(8'd0);
      chk_both("hold0_done", 1'b1, 1'b0, 8'd0);
      clear();

      // 4: clear in the middle of a count, then a short hold
      fire(8'd10);
      chk_both("mid_c10", 1'b0, 1'b1, 8'd10);
      for (int i = 0; i < 4; i++) tick();
      chk_both("mid_c6", 1'b0, 1'b1, 8'd6);
      clear();
      chk_both("mid_clear", 1'b0, 1'b0, 8'd0);
      fire(8'd2);
      chk_both("mid_c2", 1'b0, 1'b1, 8'd2);
      tick();
      chk_both("mid_c1", 1'b0, 1'b1, 8'd1);
      tick();
      chk_both("mid_done", 1'b1, 1'b0, 8'd0);
      clear();

      // 5a: RESET beats START in IDLE
      RESET = 1'b1;
      START = 1'b1;
      HOLD_CYCLES = 8'd7;
      tick();
      chk_both("rst_start_idle", 1'b0, 1'b0, 8'd0);
      RESET = 1'b0;
      START = 1'b0;
      tick();
      chk_both("rst_start_stay", 1'b0, 1'b0, 8'd0);

      // 5b: START while counting is ignored without retrigger
      fire(8'd4);
      tick();
      tick();
      chk(0, "ign_c2", 1'b0, 1'b1, 8'd2);
      START = 1'b1;
      HOLD_CYCLES = 8'd9;
      tick();
      START = 1'b0;
      chk(0, "ign_c1", 1'b0, 1'b1, 8'd1);
      tick();
      chk(0, "ign_done", 1'b1, 1'b0, 8'd0);
      clear();

      // 5c: HOLD_CYCLES changes during COUNT have no effect
      fire(8'd3);
      HOLD_CYCLES = 8'd200;
      chk_both("hchg_c3", 1'b0, 1'b1, 8'd3);
      tick();
      chk_both("hchg_c2", 1'b0, 1'b1, 8'd2);
      tick();
      chk_both("hchg_c1", 1'b0, 1'b1, 8'd1);
      tick();
      chk_both("hchg_done", 1'b1, 1'b0, 8'd0);
      clear();

      // 6: retrigger at COUNT=2 reloads with the new hold
      fire(8'd4);
      chk(1, "rtg_c4", 1'b0, 1'b1, 8'd4);
      tick();
      tick();
      chk(1, "rtg_c2", 1'b0, 1'b1, 8'd2);
      fire(8'd5);
      chk(1, "rtg_reload", 1'b0, 1'b1, 8'd5);
      chk(0, "rtg_noreload", 1'b0, 1'b1, 8'd1);
      for (int i = 4; i >= 1; i--) begin
         tick();
         chk(1, "rtg_count", 1'b0, 1'b1, W'(i));
      end
      tick();
      chk(1, "rtg_done", 1'b1, 1'b0, 8'd0);
      clear();

      // 6b: retrigger with a zero hold finishes at once
      fire(8'd3);
      fire(8'd0);
      chk(1, "rtg_zero_done", 1'b1, 1'b0, 8'd0);
      chk(0, "rtg_zero_ign", 1'b0, 1'b1, 8'd2);
      clear();

      // 6c: maximum hold, no wrap
      fire(8'd255);
      chk_both("max_c255", 1'b0, 1'b1, 8'd255);
      for (int i = 254; i >= 1; i--) begin
         tick();
         if (i == 128 || i == 1) chk_both("max_count", 1'b0, 1'b1, W'(i));
      end
      tick();
      chk_both("max_done", 1'b1, 1'b0, 8'd0);
      tick();
      chk_both("max_nowrap", 1'b1, 1'b0, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
